// File: rtl/dispatch_rr4_if.sv
// dispatch_rr4_if: token handshake and demux-control bundle for dispatch_rr4.
//   in_valid / in_ready : token offer and acceptance
//   ch_mask             : per-channel eligibility
//   done                : per-channel credit return pulses
//   drain               : level request to stop intake and wait for all credits
//   E / sel             : demux enable pulse and channel select
//   busy                : per-channel "no credits left" flags
//   drained / err       : drain complete, sticky credit-overflow flag
// Modports: master = token source / credit returner, slave = dispatcher.
interface dispatch_rr4_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] ch_mask;
  logic [3:0] done;
  logic       drain;
  logic       E;
  logic [1:0] sel;
  logic [3:0] busy;
  logic       drained;
  logic       err;

  modport master (
    output in_valid,
    output ch_mask,
    output done,
    output drain,
    input  in_ready,
    input  E,
    input  sel,
    input  busy,
    input  drained,
    input  err
  );

  modport slave (
    input  in_valid,
    input  ch_mask,
    input  done,
    input  drain,
    output in_ready,
    output E,
    output sel,
    output busy,
    output drained,
    output err
  );
endinterface

// File: rtl/dispatch_rr4.sv
// dispatch_rr4: round-robin token dispatcher driving a 1-to-4 demux (E/sel).
// Each accepted token goes to the first eligible channel at or after the rotating
// pointer; per-channel credit counters bound the outstanding tokens per channel.
// A drain request stops intake and reports when every credit has come home.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dispatch_rr4_if.slave (handshake, mask, credit returns, demux control, status)
module dispatch_rr4 #(
  parameter  int unsigned CREDITS = 2,
  localparam int unsigned CW      = $clog2(CREDITS + 1)
) (
  input logic           clk,
  input logic           rst_n,
  dispatch_rr4_if.slave bus
);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(CREDITS);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  cnt_t       cnt_q [4];
  cnt_t       cnt_d [4];
  logic [1:0] ptr_q, ptr_d;
  logic       e_q, e_d;
  logic [1:0] sel_q, sel_d;
  logic       err_q, err_d;

  logic [3:0] zero_cnt;
  logic [3:0] elig;
  logic       any_elig;
  logic [1:0] pick;
  logic       ready_int;
  logic       hs;
  logic       err_set;
  logic       all_full_d;

  // Eligibility and rotating pick from registered credits and live mask.
  always_comb begin
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      zero_cnt[i] = (cnt_q[i] == '0);
    end
    elig     = bus.ch_mask & ~zero_cnt;
    any_elig = |elig;
    pick     = ptr_q;
    // Walk from farthest to nearest so the nearest eligible offset wins.
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (elig[idx]) begin
        pick = idx;
      end
    end
  end

  assign ready_int = (state_q == StRun) && any_elig;
  assign hs        = bus.in_valid && ready_int;

  // Credit bookkeeping: same-cycle dispatch and return to one channel cancel out;
  // a return to a full channel is dropped and flagged.
  always_comb begin
    logic dec;
    logic inc;
    dec        = 1'b0;
    inc        = 1'b0;
    err_set    = 1'b0;
    all_full_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dec      = hs && (pick == 2'(i));
      inc      = bus.done[i];
      cnt_d[i] = cnt_q[i];
      if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - cnt_t'(1);
      end else if (!dec && inc) begin
        if (cnt_q[i] == CntMax) begin
          err_set = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + cnt_t'(1);
        end
      end
      if (cnt_d[i] != CntMax) begin
        all_full_d = 1'b0;
      end
    end
  end

  // Pointer, demux control and sticky error.
  always_comb begin
    ptr_d = ptr_q;
    sel_d = sel_q;
    e_d   = hs;
    err_d = err_q | err_set;
    if (hs) begin
      ptr_d = pick + 2'd1;
      sel_d = pick;
    end
  end

  // Drain FSM. DONE is entered on the edge that completes the last credit return,
  // so drained rises one cycle after the final done pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (bus.drain) state_d = StDrain;
      end
      StDrain: begin
        if (!bus.drain)     state_d = StRun;
        else if (all_full_d) state_d = StDone;
      end
      StDone: begin
        if (!bus.drain) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      ptr_q   <= '0;
      e_q     <= 1'b0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= CntMax;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      e_q     <= e_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // rst_n gates in_ready so nothing is offered while reset is held.
  assign bus.in_ready = rst_n && ready_int;
  assign bus.E        = e_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = zero_cnt;
  assign bus.drained  = (state_q == StDone);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_dispatch_rr4.sv
module tb_dispatch_rr4;
  localparam int CREDITS = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dispatch_rr4_if bus ();

  dispatch_rr4 #(.CREDITS(CREDITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int sel_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string name, input int exp[$]);
    chk({name, " count"}, sel_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < sel_log.size(); i++) begin
      chk($sformatf("%s sel[%0d]", name, i), sel_log[i], exp[i]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Credits as plain integers, mode 0=run 1=drain 2=done.
  int cr[4] = '{CREDITS, CREDITS, CREDITS, CREDITS};
  int mptr  = 0;
  int mmode = 0;
  bit me    = 0;
  int msel  = 0;
  bit merr  = 0;

  function automatic bit model_ready();
    bit r;
    r = 0;
    for (int i = 0; i < 4; i++) if (bus.ch_mask[i] && cr[i] > 0) r = 1;
    return (mmode == 0) && r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int  ncr[4];
    int  pk;
    int  idx;
    bit  hs;
    bit  ovf;
    bit  full;
    int  nm;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cr[i] <= CREDITS;
      mptr  <= 0;
      mmode <= 0;
      me    <= 0;
      msel  <= 0;
      merr  <= 0;
    end else begin
      pk = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (mptr + k) % 4;
        if (pk < 0 && bus.ch_mask[idx] && cr[idx] > 0) pk = idx;
      end
      hs   = bus.in_valid && model_ready();
      ovf  = 0;
      full = 1;
      for (int i = 0; i < 4; i++) begin
        ncr[i] = cr[i] + int'(bus.done[i]) - int'(hs && pk == i);
        if (ncr[i] > CREDITS) begin
          ncr[i] = CREDITS;
          ovf = 1;
        end
        if (ncr[i] != CREDITS) full = 0;
      end
      nm = mmode;
      case (mmode)
        0: if (bus.drain) nm = 1;
        1: if (!bus.drain) nm = 0; else if (full) nm = 2;
        default: if (!bus.drain) nm = 0;
      endcase
      for (int i = 0; i < 4; i++) cr[i] <= ncr[i];
      mmode <= nm;
      me    <= hs;
      if (hs) begin
        msel <= pk;
        mptr <= (pk + 1) % 4;
      end
      if (ovf) merr <= 1;
    end
  end

  // Compare process: every cycle out of reset, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] eb;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) eb[i] = (cr[i] == 0);
      chk("E", bus.E, me);
      chk("sel", bus.sel, msel);
      chk("in_ready", bus.in_ready, model_ready());
      chk("busy", bus.busy, eb);
      chk("drained", bus.drained, mmode == 2);
      chk("err", bus.err, merr);
      if (bus.E) sel_log.push_back(int'(bus.sel));
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.ch_mask  = 4'hF;
    bus.done     = 4'h0;
    bus.drain    = 1'b0;
    #12;
    chk("rst in_ready", bus.in_ready, 1'b0);
    chk("rst E", bus.E, 1'b0);
    chk("rst sel", bus.sel, 2'd0);
    chk("rst busy", bus.busy, 4'h0);
    chk("rst drained", bus.drained, 1'b0);
    chk("rst err", bus.err, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Round robin over all four channels.
    sel_log.delete();
    bus.in_valid = 1'b1;
    repeat (4) cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk_log("rr4", '{0, 1, 2, 3});

    // Exhaust credits, then a single return on channel 2.
    bus.in_valid = 1'b1;
    repeat (6) cyc();
    chk_log("rr8", '{0, 1, 2, 3, 0, 1, 2, 3});
    chk("exhaust in_ready", bus.in_ready, 1'b0);
    chk("exhaust busy", bus.busy, 4'hF);
    bus.done = 4'b0100;
    cyc();
    bus.done = 4'h0;
    chk("return in_ready", bus.in_ready, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk("return sel count", sel_log.size(), 9);
    chk("return sel", sel_log[sel_log.size()-1], 2);

    // Refill, move pointer to 0, then masked dispatch 1,3,1,3.
    bus.done = 4'hF;
    repeat (2) cyc();
    bus.done = 4'h0;
    bus.ch_mask = 4'b1000;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    bus.done = 4'b1000;
    cyc();
    bus.done = 4'h0;
    bus.ch_mask = 4'b1010;
    sel_log.delete();
    bus.in_valid = 1'b1;
    repeat (4) cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk_log("mask1010", '{1, 3, 1, 3});
    chk("mask in_ready", bus.in_ready, 1'b0);
    bus.done = 4'b1010;
    repeat (2) cyc();
    bus.done = 4'h0;

    // Same-cycle dispatch and return on channel 0, then overflow error.
    bus.ch_mask = 4'b0001;
    bus.in_valid = 1'b1;
    cyc();
    bus.done = 4'b0001;
    cyc();
    bus.done = 4'h0;
    bus.in_valid = 1'b0;
    chk("cancel busy", bus.busy, 4'h0);
    chk("cancel in_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("ch0 empty busy", bus.busy, 4'b0001);
    chk("ch0 empty in_ready", bus.in_ready, 1'b0);
    bus.done = 4'b0001;
    repeat (2) cyc();
    chk("pre-ovf err", bus.err, 1'b0);
    cyc();
    bus.done = 4'h0;
    chk("ovf err", bus.err, 1'b1);
    repeat (3) cyc();
    chk("ovf err sticky", bus.err, 1'b1);

    // Drain with three tokens outstanding.
    bus.ch_mask = 4'hF;
    bus.in_valid = 1'b1;
    repeat (3) cyc();
    bus.in_valid = 1'b0;
    bus.drain = 1'b1;
    cyc();
    chk("drain in_ready", bus.in_ready, 1'b0);
    chk("drain drained", bus.drained, 1'b0);
    bus.done = 4'b0010;
    cyc();
    bus.done = 4'b0100;
    cyc();
    chk("drain partial", bus.drained, 1'b0);
    bus.done = 4'b1000;
    cyc();
    bus.done = 4'h0;
    chk("drain done", bus.drained, 1'b1);
    bus.drain = 1'b0;
    cyc();
    chk("undrain in_ready", bus.in_ready, 1'b1);
    chk("undrain drained", bus.drained, 1'b0);

    // Drain withdrawn while tokens are outstanding.
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    bus.drain = 1'b1;
    repeat (2) cyc();
    chk("abort drained", bus.drained, 1'b0);
    chk("abort in_ready", bus.in_ready, 1'b0);
    bus.drain = 1'b0;
    cyc();
    chk("abort run in_ready", bus.in_ready, 1'b1);
    bus.done = 4'b0001;
    cyc();
    bus.done = 4'h0;

    // Asynchronous reset while E is high.
    bus.ch_mask = 4'b0010;
    bus.in_valid = 1'b1;
    repeat (2) cyc();
    chk("pre-rst E", bus.E, 1'b1);
    chk("pre-rst sel", bus.sel, 2'd1);
    chk("pre-rst busy", bus.busy, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("async E", bus.E, 1'b0);
    chk("async sel", bus.sel, 2'd0);
    chk("async busy", bus.busy, 4'h0);
    chk("async err", bus.err, 1'b0);
    chk("async drained", bus.drained, 1'b0);
    chk("async in_ready", bus.in_ready, 1'b0);
    #2;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.ch_mask = 4'hF;
    cyc();
    sel_log.delete();
    bus.in_valid = 1'b1;
    repeat (10) cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk_log("post-rst", '{0, 1, 2, 3, 0, 1, 2, 3});
    chk("post-rst busy", bus.busy, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
